// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if #(
  parameter int OP_W   = 5,
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
) ();
  logic [REG_W-1:0]  FD_src_a;
  logic [REG_W-1:0]  FD_src_b;
  logic              FD_uses_b;
  logic [OP_W-1:0]   DX_opcode;
  logic [REG_W-1:0]  DX_rd;
  logic [REG_W-1:0]  DX_src_a;
  logic [REG_W-1:0]  DX_src_b;
  logic [REG_W-1:0]  XM_rd;
  logic              XM_we;
  logic [REG_W-1:0]  MW_rd;
  logic              MW_we;
  logic              md_req;
  logic              md_is_div;
  logic              branch_taken;
  logic              stall_fd;
  logic              stall_dx;
  logic              bubble_dx;
  logic              bubble_xm;
  logic              flush_fd;
  logic              md_start;
  logic              md_is_div_q;
  logic              md_done;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [PERF_W-1:0] stall_count;

  // Pipeline/decode side: drives stage contents, consumes control strobes
  modport master (
    output FD_src_a, FD_src_b, FD_uses_b, DX_opcode, DX_rd, DX_src_a, DX_src_b,
           XM_rd, XM_we, MW_rd, MW_we, md_req, md_is_div, branch_taken,
    input  stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, md_start,
           md_is_div_q, md_done, fwd_a_sel, fwd_b_sel, stall_count
  );

  // Hazard controller side
  modport slave (
    input  FD_src_a, FD_src_b, FD_uses_b, DX_opcode, DX_rd, DX_src_a, DX_src_b,
           XM_rd, XM_we, MW_rd, MW_we, md_req, md_is_div, branch_taken,
    output stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd, md_start,
           md_is_div_q, md_done, fwd_a_sel, fwd_b_sel, stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - interlock, forwarding and mult/div sequencing controller
module hazard_ctrl #(
  parameter int OP_W        = 5,
  parameter int REG_W       = 5,
  parameter int LW_OP       = 8,
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 33,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic       clock,
  input  logic       reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  // Counter preload: the start cycle and the DONE cycle are not BUSY cycles
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
  localparam logic [OP_W-1:0]  LW_CODE   = OP_W'(LW_OP);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [PERF_W-1:0] perf_q, perf_d;

  logic start_c, load_use_c;
  logic stall_fd_c, stall_dx_c, bubble_dx_c, bubble_xm_c, flush_fd_c;
  logic md_start_c, md_done_c;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign start_c = hz.md_req && !hz.branch_taken;

  // Load in DX whose destination the FD instruction reads; $0 is never a hazard
  assign load_use_c = (hz.DX_opcode == LW_CODE) && (hz.DX_rd != '0) &&
                      ((hz.DX_rd == hz.FD_src_a) ||
                       (hz.FD_uses_b && (hz.DX_rd == hz.FD_src_b)));

  // State, latency counter, op type and stall counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      perf_q  <= perf_d;
    end
  end

  // Next-state logic for the mult/div sequencer; md_req in DONE is the same op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = BUSY;
          div_d   = hz.md_is_div;
          cnt_d   = hz.md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe outputs; all forced low while reset is asserted
  always_comb begin
    stall_fd_c  = 1'b0;
    stall_dx_c  = 1'b0;
    bubble_dx_c = 1'b0;
    bubble_xm_c = 1'b0;
    flush_fd_c  = 1'b0;
    md_start_c  = 1'b0;
    md_done_c   = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (hz.branch_taken) begin
            flush_fd_c  = 1'b1;
            bubble_dx_c = 1'b1;
          end else if (start_c) begin
            md_start_c  = 1'b1;
            stall_fd_c  = 1'b1;
            stall_dx_c  = 1'b1;
            bubble_xm_c = 1'b1;
          end else if (load_use_c) begin
            stall_fd_c  = 1'b1;
            bubble_dx_c = 1'b1;
          end
        end
        BUSY: begin
          stall_fd_c  = 1'b1;
          stall_dx_c  = 1'b1;
          bubble_xm_c = 1'b1;
        end
        DONE:    md_done_c = 1'b1;
        default: md_done_c = 1'b0;
      endcase
    end
  end

  // Operand bypass selects: XM is younger so it wins over MW; $0 never forwards
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (hz.XM_we && (hz.XM_rd != '0) && (hz.XM_rd == hz.DX_src_a))      fwd_a_c = 2'b01;
    else if (hz.MW_we && (hz.MW_rd != '0) && (hz.MW_rd == hz.DX_src_a)) fwd_a_c = 2'b10;
    if (hz.XM_we && (hz.XM_rd != '0) && (hz.XM_rd == hz.DX_src_b))      fwd_b_c = 2'b01;
    else if (hz.MW_we && (hz.MW_rd != '0) && (hz.MW_rd == hz.DX_src_b)) fwd_b_c = 2'b10;
  end

  // Saturating count of cycles spent with the front end held
  always_comb begin
    perf_d = perf_q;
    if (stall_fd_c && !(&perf_q)) perf_d = perf_q + 1'b1;
  end

  assign hz.stall_fd    = stall_fd_c;
  assign hz.stall_dx    = stall_dx_c;
  assign hz.bubble_dx   = bubble_dx_c;
  assign hz.bubble_xm   = bubble_xm_c;
  assign hz.flush_fd    = flush_fd_c;
  assign hz.md_start    = md_start_c;
  assign hz.md_done     = md_done_c;
  assign hz.md_is_div_q = div_q;
  assign hz.fwd_a_sel   = fwd_a_c;
  assign hz.fwd_b_sel   = fwd_b_c;
  assign hz.stall_count = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  hazard_ctrl_if #(.OP_W(5), .REG_W(5), .PERF_W(16)) hz ();
  hazard_ctrl_if #(.OP_W(5), .REG_W(5), .PERF_W(4))  hz2 ();

  hazard_ctrl #(
    .OP_W(5), .REG_W(5), .LW_OP(8), .MULT_CYCLES(32), .DIV_CYCLES(33),
    .CNT_W(6), .PERF_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hz(hz)
  );

  hazard_ctrl #(
    .OP_W(5), .REG_W(5), .LW_OP(8), .MULT_CYCLES(20), .DIV_CYCLES(20),
    .CNT_W(5), .PERF_W(4)
  ) dut_sat (
    .clock(clock),
    .reset(reset),
    .hz(hz2)
  );

  typedef struct {
    logic [4:0] fa, fb;
    logic       ub;
    logic [4:0] op, drd, dsa, dsb, xrd;
    logic       xwe;
    logic [4:0] mrd;
    logic       mwe;
    logic       br;
    logic       e_stall, e_bub, e_flush;
    logic [1:0] e_fa, e_fb;
    string      name;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs();
    hz.FD_src_a = '0; hz.FD_src_b = '0; hz.FD_uses_b = 1'b0;
    hz.DX_opcode = '0; hz.DX_rd = '0; hz.DX_src_a = '0; hz.DX_src_b = '0;
    hz.XM_rd = '0; hz.XM_we = 1'b0; hz.MW_rd = '0; hz.MW_we = 1'b0;
    hz.md_req = 1'b0; hz.md_is_div = 1'b0; hz.branch_taken = 1'b0;
    hz2.FD_src_a = '0; hz2.FD_src_b = '0; hz2.FD_uses_b = 1'b0;
    hz2.DX_opcode = '0; hz2.DX_rd = '0; hz2.DX_src_a = '0; hz2.DX_src_b = '0;
    hz2.XM_rd = '0; hz2.XM_we = 1'b0; hz2.MW_rd = '0; hz2.MW_we = 1'b0;
    hz2.md_req = 1'b0; hz2.md_is_div = 1'b0; hz2.branch_taken = 1'b0;
  endtask

  task automatic check_md(input string tag, input int c, input logic e_start,
                          input logic e_stall, input logic e_done);
    chk($sformatf("%s_start_c%0d", tag, c), hz.md_start, e_start);
    chk($sformatf("%s_stall_fd_c%0d", tag, c), hz.stall_fd, e_stall);
    chk($sformatf("%s_stall_dx_c%0d", tag, c), hz.stall_dx, e_stall);
    chk($sformatf("%s_bubble_xm_c%0d", tag, c), hz.bubble_xm, e_stall);
    chk($sformatf("%s_done_c%0d", tag, c), hz.md_done, e_done);
  endtask

  initial begin
    int exp_cnt;
    int starts;

    vecs[0]  = '{5'd1, 5'd5, 1'b1, 5'd8, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "lu_src_b"};
    vecs[1]  = '{5'd1, 5'd0, 1'b1, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "lu_rd0"};
    vecs[2]  = '{5'd1, 5'd5, 1'b0, 5'd8, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "lu_no_use_b"};
    vecs[3]  = '{5'd7, 5'd2, 1'b0, 5'd8, 5'd7, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, "lu_src_a"};
    vecs[4]  = '{5'd5, 5'd2, 1'b1, 5'd3, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "not_load"};
    vecs[5]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, "fwd_xm_prio"};
    vecs[6]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, "fwd_mw"};
    vecs[7]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "fwd_r0"};
    vecs[8]  = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd3, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, "fwd_mixed"};
    vecs[9]  = '{5'd1, 5'd5, 1'b1, 5'd8, 5'd5, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, "branch_over_lu"};
    vecs[10] = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, "branch"};
    vecs[11] = '{5'd1, 5'd2, 1'b0, 5'd0, 5'd0, 5'd3, 5'd3, 5'd3, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, "fwd_no_we"};

    // Reset cycle: strobes low even with a start request and a load-use present
    reset = 1'b1;
    zero_inputs();
    hz.md_req = 1'b1; hz.DX_opcode = 5'd8; hz.DX_rd = 5'd5; hz.FD_src_a = 5'd5;
    #4;
    chk("rst_stall_fd", hz.stall_fd, 1'b0);
    chk("rst_bubble_dx", hz.bubble_dx, 1'b0);
    chk("rst_md_start", hz.md_start, 1'b0);
    chk("rst_stall_dx", hz.stall_dx, 1'b0);
    next_cycle();
    reset = 1'b0;
    zero_inputs();
    #3;
    chk("rst_stall_count", hz.stall_count, 16'd0);
    chk("rst_md_is_div_q", hz.md_is_div_q, 1'b0);
    chk("rst_md_done", hz.md_done, 1'b0);
    chk("rst_idle_stall", hz.stall_fd, 1'b0);
    next_cycle();

    // Combinational vectors in IDLE
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      hz.FD_src_a = vecs[i].fa;  hz.FD_src_b = vecs[i].fb;  hz.FD_uses_b = vecs[i].ub;
      hz.DX_opcode = vecs[i].op; hz.DX_rd = vecs[i].drd;
      hz.DX_src_a = vecs[i].dsa; hz.DX_src_b = vecs[i].dsb;
      hz.XM_rd = vecs[i].xrd;    hz.XM_we = vecs[i].xwe;
      hz.MW_rd = vecs[i].mrd;    hz.MW_we = vecs[i].mwe;
      hz.branch_taken = vecs[i].br;
      #3;
      chk({vecs[i].name, "_stall_fd"},  hz.stall_fd,  vecs[i].e_stall);
      chk({vecs[i].name, "_bubble_dx"}, hz.bubble_dx, vecs[i].e_bub);
      chk({vecs[i].name, "_flush_fd"},  hz.flush_fd,  vecs[i].e_flush);
      chk({vecs[i].name, "_fwd_a"},     hz.fwd_a_sel, vecs[i].e_fa);
      chk({vecs[i].name, "_fwd_b"},     hz.fwd_b_sel, vecs[i].e_fb);
      chk({vecs[i].name, "_stall_dx"},  hz.stall_dx,  1'b0);
      chk({vecs[i].name, "_bubble_xm"}, hz.bubble_xm, 1'b0);
      if (vecs[i].e_stall) exp_cnt++;
      next_cycle();
    end
    zero_inputs();
    #3;
    chk("table_stall_count", hz.stall_count, exp_cnt);
    next_cycle();

    // Mult: md_req pulse at c=10, stalls 10..41, done at 42
    for (int c = 0; c < 46; c++) begin
      hz.md_req = (c == 10);
      hz.md_is_div = 1'b0;
      #3;
      check_md("mult", c, c == 10, (c >= 10) && (c <= 41), c == 42);
      next_cycle();
    end
    exp_cnt += 32;
    #3;
    chk("mult_stall_count", hz.stall_count, exp_cnt);
    chk("mult_is_div_q", hz.md_is_div_q, 1'b0);
    next_cycle();

    // Div: md_req held through the DONE cycle, must not retrigger
    starts = 0;
    for (int c = 0; c < 37; c++) begin
      hz.md_req = (c <= 33);
      hz.md_is_div = 1'b1;
      #3;
      if (hz.md_start) starts++;
      check_md("div", c, c == 0, c <= 32, c == 33);
      if (c == 5) chk("div_is_div_q", hz.md_is_div_q, 1'b1);
      next_cycle();
    end
    zero_inputs();
    exp_cnt += 33;
    #3;
    chk("div_start_count", starts, 1);
    chk("div_stall_count", hz.stall_count, exp_cnt);
    next_cycle();

    // Reset asserted while BUSY: no md_done afterwards, counter cleared
    for (int c = 0; c < 41; c++) begin
      hz.md_req = (c == 0);
      reset = (c == 5);
      #3;
      check_md("rstbusy", c, c == 0, c <= 4, 1'b0);
      if (c == 5) begin
        chk("rstbusy_bubble_dx", hz.bubble_dx, 1'b0);
        chk("rstbusy_flush_fd", hz.flush_fd, 1'b0);
      end
      if (c == 6) begin
        chk("rstbusy_stall_count", hz.stall_count, 16'd0);
        chk("rstbusy_is_div_q", hz.md_is_div_q, 1'b0);
      end
      next_cycle();
    end
    reset = 1'b0;
    zero_inputs();

    // Saturation: 20 stall cycles into a 4-bit counter
    for (int c = 0; c < 23; c++) begin
      hz2.md_req = (c == 0);
      #3;
      chk($sformatf("sat_done_c%0d", c), hz2.md_done, c == 20);
      next_cycle();
    end
    #3;
    chk("sat_stall_count", hz2.stall_count, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
